// File: rtl/fsum_pkg.sv
// Shared constants, state encoding and binary32 field helpers for the
// fsum_acc streaming accumulator and its adder.
package fsum_pkg;

  localparam logic [7:0]  EXP_INF = 8'hFF;
  localparam logic [31:0] FZERO   = 32'h0000_0000;
  localparam logic [31:0] FNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_HOLD
  } fsum_state_t;

  function automatic logic f_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] f_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] f_mant(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/fsum_acc_fadd.sv
// Combinational binary32 adder: round-to-nearest-even, gradual underflow,
// NaN results are returned as the canonical quiet NaN.
module fadd
  import fsum_pkg::*;
(
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf
);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  logic [31:0] a, b;
  logic        x1_nan, x2_nan, x1_inf, x2_inf, lost, rup;
  logic [7:0]  ea, eb, dexp, eam1;
  logic [23:0] ma, mb;
  logic [26:0] big, sml_raw, sml, norm;
  logic [27:0] sum;
  logic [4:0]  lz, sh;
  logic [8:0]  en;
  logic [30:0] mag;

  always_comb begin
    x1_nan = (f_exp(x1) == EXP_INF) && (f_mant(x1) != 23'd0);
    x2_nan = (f_exp(x2) == EXP_INF) && (f_mant(x2) != 23'd0);
    x1_inf = (f_exp(x1) == EXP_INF) && (f_mant(x1) == 23'd0);
    x2_inf = (f_exp(x2) == EXP_INF) && (f_mant(x2) == 23'd0);

    // Order by magnitude so alignment only ever shifts the smaller operand.
    if (x1[30:0] >= x2[30:0]) begin
      a = x1;
      b = x2;
    end else begin
      a = x2;
      b = x1;
    end

    ea      = (f_exp(a) == 8'd0) ? 8'd1 : f_exp(a);
    eb      = (f_exp(b) == 8'd0) ? 8'd1 : f_exp(b);
    ma      = {f_exp(a) != 8'd0, f_mant(a)};
    mb      = {f_exp(b) != 8'd0, f_mant(b)};
    dexp    = ea - eb;
    big     = {ma, 3'b000};
    sml_raw = {mb, 3'b000};
    lost    = 1'b0;
    if (dexp > 8'd26) begin
      sml = {26'd0, |mb};
    end else begin
      lost = |(sml_raw & ~({27{1'b1}} << dexp));
      sml  = (sml_raw >> dexp) | {26'd0, lost};
    end

    if (f_sign(a) == f_sign(b)) sum = {1'b0, big} + {1'b0, sml};
    else                        sum = {1'b0, big} - {1'b0, sml};

    // Left normalisation stops at exponent 1, leaving subnormals in place.
    lz   = lzc27(sum[26:0]);
    eam1 = ea - 8'd1;
    if (sum[27]) begin
      sh   = 5'd0;
      norm = sum[27:1] | {26'd0, sum[0]};
      en   = {1'b0, ea} + 9'd1;
    end else begin
      sh   = ({3'd0, lz} > eam1) ? eam1[4:0] : lz;
      norm = sum[26:0] << sh;
      en   = {1'b0, ea} - {4'd0, sh};
      if (!norm[26]) en = 9'd0;
    end

    // A rounding carry ripples into the exponent field, including to infinity.
    rup = norm[2] && (norm[1] || norm[0] || norm[3]);
    mag = {en[7:0], norm[25:3]} + {30'd0, rup};

    y   = {f_sign(a), mag};
    ovf = 1'b0;
    if (x1_nan || x2_nan || (x1_inf && x2_inf && (f_sign(x1) != f_sign(x2)))) begin
      y = FNAN;
    end else if (x1_inf) begin
      y = x1;
    end else if (x2_inf) begin
      y = x2;
    end else if (sum == 28'd0) begin
      y = {f_sign(x1) & f_sign(x2), 31'd0};
    end else if (en >= 9'd255) begin
      y   = {f_sign(a), EXP_INF, 23'd0};
      ovf = 1'b1;
    end else begin
      ovf = (mag[30:23] == EXP_INF);
    end
  end

endmodule

// File: rtl/fsum_acc.sv
// Streaming binary32 group accumulator in front of fadd; one registered sum
// plus sticky overflow per group. Optional negate input via FSUM_SUB_EN.
module fsum_acc
  import fsum_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
`ifdef FSUM_SUB_EN
  input  logic        in_sub,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ovf,
  output logic        busy
);

  fsum_state_t state_q, state_d;
  logic        op_v_q, op_v_d, op_last_q, op_last_d, op_first_q, op_first_d;
  logic [31:0] op_data_q, op_data_d, acc_q, acc_d, out_data_q, out_data_d;
  logic        ovf_acc_q, ovf_acc_d, out_ovf_q, out_ovf_d;
  logic [31:0] in_op, sum;
  logic        ovf_c, accept;

`ifdef FSUM_SUB_EN
  assign in_op = {in_data[31] ^ in_sub, in_data[30:0]};
`else
  assign in_op = in_data;
`endif

  fadd u_fadd (
    .x1  (acc_q),
    .x2  (op_data_q),
    .y   (sum),
    .ovf ()
  );

  assign ovf_c = (f_exp(sum) == EXP_INF) && (f_exp(acc_q) != EXP_INF)
              && (f_exp(op_data_q) != EXP_INF);

  // A finished group blocks new input until its result has been taken.
  assign in_ready  = (state_q != S_HOLD) && !(op_v_q && op_last_q);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_HOLD);
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = (state_q != S_IDLE) || op_v_q;

  always_comb begin
    state_d    = state_q;
    op_v_d     = accept;
    op_data_d  = op_data_q;
    op_last_d  = op_last_q;
    op_first_d = op_first_q;
    acc_d      = acc_q;
    ovf_acc_d  = ovf_acc_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;

    if (accept) begin
      op_data_d  = in_op;
      op_last_d  = in_last;
      op_first_d = (state_q == S_IDLE);
    end

    // The first element bypasses the adder so -0 and NaN payloads survive.
    if (op_v_q) begin
      acc_d     = op_first_q ? op_data_q : sum;
      ovf_acc_d = !op_first_q && (ovf_acc_q || ovf_c);
    end

    unique case (state_q)
      S_IDLE: if (accept) state_d = S_ACC;
      S_ACC: begin
        if (op_v_q && op_last_q) begin
          state_d    = S_HOLD;
          out_data_d = acc_d;
          out_ovf_d  = ovf_acc_d;
        end
      end
      S_HOLD: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_v_q     <= 1'b0;
      op_data_q  <= FZERO;
      op_last_q  <= 1'b0;
      op_first_q <= 1'b0;
      acc_q      <= FZERO;
      ovf_acc_q  <= 1'b0;
      out_data_q <= FZERO;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_v_q     <= op_v_d;
      op_data_q  <= op_data_d;
      op_last_q  <= op_last_d;
      op_first_q <= op_first_d;
      acc_q      <= acc_d;
      ovf_acc_q  <= ovf_acc_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

endmodule
